// File: rtl/caterr_pkg.sv
// Shared CATERR constants and FSM encodings.
// Also used by the CATERR delay path.
package caterr_pkg;

    localparam logic [31:0] T_GLITCH_50M_DEF = 32'd2;
    localparam logic [31:0] T_IERR_50M_DEF   = 32'd25000;
    localparam int          CNT_W_DEF        = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b001,
        ST_MEASURE   = 3'b010,
        ST_IERR_HOLD = 3'b100
    } caterr_state_e;

endpackage

// File: rtl/caterr_decode_if.sv
// Signal bundle between CATERR decoder and its environment.
// master drives the inputs, slave is the decoder.
interface caterr_decode_if;

    logic       iCpuPwrgdDly;
    logic       iCaterr_n;
    logic       iClrStatus;
    logic       oMcerrEvt;
    logic       oIerrEvt;
    logic       oMcerrSticky;
    logic       oIerrSticky;
    logic [7:0] oMcerrCnt;
    logic       oCaterrActive;

    modport master (
        output iCpuPwrgdDly, iCaterr_n, iClrStatus,
        input  oMcerrEvt, oIerrEvt, oMcerrSticky,
        input  oIerrSticky, oMcerrCnt, oCaterrActive
    );

    modport slave (
        input  iCpuPwrgdDly, iCaterr_n, iClrStatus,
        output oMcerrEvt, oIerrEvt, oMcerrSticky,
        output oIerrSticky, oMcerrCnt, oCaterrActive
    );

endinterface

// File: rtl/caterr_sync.sv
// 3-flop synchronizer for raw CATERR_N.
// Force input parks the chain high (line idle).
module caterr_sync (
    input  logic iClk,
    input  logic iRst,
    input  logic iForceHigh,
    input  logic iAsync_n,
    output logic oLevel,
    output logic oFall
);

    logic r_ff1;
    logic r_ff2;
    logic r_ff3;

    // shift raw line through chain; idle level is high
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            r_ff1 <= 1'b1;
            r_ff2 <= 1'b1;
            r_ff3 <= 1'b1;
        end else if (iForceHigh) begin
            r_ff1 <= 1'b1;
            r_ff2 <= 1'b1;
            r_ff3 <= 1'b1;
        end else begin
            r_ff1 <= iAsync_n;
            r_ff2 <= r_ff1;
            r_ff3 <= r_ff2;
        end
    end

    assign oLevel = r_ff2;
    assign oFall  = ~r_ff2 & r_ff3;

endmodule

// File: rtl/caterr_decode.sv
// CATERR_N low-width classifier: short pulse = MCERR,
// held low = IERR. Keeps sticky status and MCERR count.
module caterr_decode
    import caterr_pkg::*;
#(
    parameter logic [31:0] T_GLITCH_50M = T_GLITCH_50M_DEF,
    parameter logic [31:0] T_IERR_50M   = T_IERR_50M_DEF,
    parameter int          CNT_W        = CNT_W_DEF
) (
    input logic            iClk_50M,
    input logic            iRst,
    caterr_decode_if.slave bus
);

    localparam logic [CNT_W-1:0] C_GLITCH = T_GLITCH_50M[CNT_W-1:0];
    localparam logic [CNT_W-1:0] C_IERR   = T_IERR_50M[CNT_W-1:0];
    localparam logic [CNT_W-1:0] C_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    caterr_state_e    r_state;
    caterr_state_e    w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_mcerr_evt;
    logic             r_ierr_evt;
    logic             w_mcerr_nxt;
    logic             w_ierr_nxt;
    logic             r_mcerr_sticky;
    logic             r_ierr_sticky;
    logic [7:0]       r_mcerr_cnt;
    logic             w_level;
    logic             w_fall;
    logic             w_force;

    assign w_force = ~bus.iCpuPwrgdDly;

    caterr_sync u_sync (
        .iClk       (iClk_50M),
        .iRst       (iRst),
        .iForceHigh (w_force),
        .iAsync_n   (bus.iCaterr_n),
        .oLevel     (w_level),
        .oFall      (w_fall)
    );

    // FSM state, width counter and registered event strobes
    always_ff @(posedge iClk_50M or posedge iRst) begin
        if (iRst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_mcerr_evt <= 1'b0;
            r_ierr_evt  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_mcerr_evt <= w_mcerr_nxt;
            r_ierr_evt  <= w_ierr_nxt;
        end
    end

    // next state: measure low width, classify on release or at IERR limit
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mcerr_nxt = 1'b0;
        w_ierr_nxt  = 1'b0;
        w_cnt_inc   = r_cnt + C_ONE;
        unique case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_fall) begin
                    w_state_nxt = ST_MEASURE;
                    w_cnt_nxt   = C_ONE;
                end
            end
            ST_MEASURE: begin
                if (!w_level) begin
                    if (r_cnt != C_IERR) begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                    if (w_cnt_inc == C_IERR) begin
                        w_ierr_nxt  = 1'b1;
                        w_state_nxt = ST_IERR_HOLD;
                    end
                end else begin
                    w_mcerr_nxt = (r_cnt >= C_GLITCH);
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_IERR_HOLD: begin
                if (w_level) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        if (!bus.iCpuPwrgdDly) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_mcerr_nxt = 1'b0;
            w_ierr_nxt  = 1'b0;
        end
    end

    // sticky status and saturating count; clear is applied before a same-cycle event
    always_ff @(posedge iClk_50M or posedge iRst) begin
        if (iRst) begin
            r_mcerr_sticky <= 1'b0;
            r_ierr_sticky  <= 1'b0;
            r_mcerr_cnt    <= 8'd0;
        end else if (bus.iClrStatus) begin
            r_mcerr_sticky <= r_mcerr_evt;
            r_ierr_sticky  <= r_ierr_evt;
            r_mcerr_cnt    <= {7'd0, r_mcerr_evt};
        end else begin
            if (r_mcerr_evt) begin
                r_mcerr_sticky <= 1'b1;
            end
            if (r_ierr_evt) begin
                r_ierr_sticky <= 1'b1;
            end
            if (r_mcerr_evt && (r_mcerr_cnt != 8'hFF)) begin
                r_mcerr_cnt <= r_mcerr_cnt + 8'd1;
            end
        end
    end

    assign bus.oMcerrEvt     = r_mcerr_evt;
    assign bus.oIerrEvt      = r_ierr_evt;
    assign bus.oMcerrSticky  = r_mcerr_sticky;
    assign bus.oIerrSticky   = r_ierr_sticky;
    assign bus.oMcerrCnt     = r_mcerr_cnt;
    assign bus.oCaterrActive = (r_state != ST_IDLE);

endmodule

// File: tb/tb_caterr_decode.sv
// Bench for caterr_decode: width table, saturation,
// clear/event overlap, power-good drop and async reset.
module tb_caterr_decode;

    typedef struct {
        int width;
        int kind;
    } vec_t;

    typedef struct {
        int kind;
        int at;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   checks;
    int   errors;
    int   m_cnt;
    int   m_ms;
    int   m_is;
    exp_t q[$];
    exp_t mon_e;
    int   mon_k;
    vec_t vecs[7];

    caterr_decode_if bus_if ();

    caterr_decode u_dut (
        .iClk_50M (clk),
        .iRst     (rst),
        .bus      (bus_if)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // drive one low pulse of n cycles and queue the expected strobe
    task automatic pulse(input int n, input int kind, input int gap);
        exp_t e;
        @(negedge clk);
        e.kind = kind;
        e.at   = (kind == 2) ? cyc + 25002 : cyc + n + 3;
        if (kind != 0) q.push_back(e);
        bus_if.iCaterr_n = 1'b0;
        repeat (n) @(negedge clk);
        bus_if.iCaterr_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic model_evt(input int kind);
        if (kind == 1) begin
            m_ms  = 1;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        if (kind == 2) m_is = 1;
    endtask

    task automatic chk_status(input string tag);
        chk({tag, "_msticky"}, 32'(bus_if.oMcerrSticky), 32'(m_ms));
        chk({tag, "_isticky"}, 32'(bus_if.oIerrSticky), 32'(m_is));
        chk({tag, "_cnt"}, 32'(bus_if.oMcerrCnt), 32'(m_cnt));
    endtask

    // scoreboard: every strobe must match the head of the queue
    always @(negedge clk) begin
        if (!rst && (bus_if.oMcerrEvt || bus_if.oIerrEvt)) begin
            mon_k = (bus_if.oMcerrEvt ? 1 : 0) + (bus_if.oIerrEvt ? 2 : 0);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_evt kind=%0d cyc=%0d expected none",
                         mon_k, cyc);
            end else begin
                mon_e = q.pop_front();
                chk("evt_kind", 32'(mon_k), 32'(mon_e.kind));
                chk("evt_cycle", 32'(cyc), 32'(mon_e.at));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout cyc=%0d expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        m_cnt  = 0;
        m_ms   = 0;
        m_is   = 0;
        vecs[0] = '{1, 0};
        vecs[1] = '{2, 1};
        vecs[2] = '{8, 1};
        vecs[3] = '{3, 1};
        vecs[4] = '{24999, 1};
        vecs[5] = '{25000, 2};
        vecs[6] = '{30000, 2};

        rst = 1'b1;
        bus_if.iCaterr_n    = 1'b1;
        bus_if.iCpuPwrgdDly = 1'b1;
        bus_if.iClrStatus   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mevt", 32'(bus_if.oMcerrEvt), 0);
        chk("rst_ievt", 32'(bus_if.oIerrEvt), 0);
        chk("rst_active", 32'(bus_if.oCaterrActive), 0);
        chk_status("rst");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            pulse(vecs[i].width, vecs[i].kind, 6);
            model_evt(vecs[i].kind);
            chk($sformatf("w%0d_drain", vecs[i].width), 32'(q.size()), 0);
            chk($sformatf("w%0d_active", vecs[i].width),
                32'(bus_if.oCaterrActive), 0);
            chk_status($sformatf("w%0d", vecs[i].width));
        end

        for (int i = 0; i < 260; i++) begin
            pulse(2, 1, 3);
            model_evt(1);
        end
        repeat (6) @(negedge clk);
        chk("sat_drain", 32'(q.size()), 0);
        chk_status("sat");
        chk("sat_ff", 32'(bus_if.oMcerrCnt), 32'hFF);

        // clear lands on the same cycle as an MCERR strobe
        @(negedge clk);
        mon_e.kind = 1;
        mon_e.at   = cyc + 5;
        q.push_back(mon_e);
        bus_if.iCaterr_n = 1'b0;
        repeat (2) @(negedge clk);
        bus_if.iCaterr_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("clr_strobe", 32'(bus_if.oMcerrEvt), 1);
        bus_if.iClrStatus = 1'b1;
        @(negedge clk);
        bus_if.iClrStatus = 1'b0;
        @(negedge clk);
        m_cnt = 1;
        m_ms  = 1;
        m_is  = 0;
        chk_status("clr");
        chk("clr_drain", 32'(q.size()), 0);

        // power-good drop in the middle of a measurement
        @(negedge clk);
        bus_if.iCaterr_n = 1'b0;
        repeat (10) @(negedge clk);
        chk("pg_active_hi", 32'(bus_if.oCaterrActive), 1);
        bus_if.iCpuPwrgdDly = 1'b0;
        @(negedge clk);
        chk("pg_active_lo", 32'(bus_if.oCaterrActive), 0);
        repeat (5) @(negedge clk);
        bus_if.iCaterr_n = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.iCpuPwrgdDly = 1'b1;
        repeat (10) @(negedge clk);
        chk("pg_idle", 32'(bus_if.oCaterrActive), 0);
        chk_status("pg");

        // asynchronous reset mid-assertion
        @(negedge clk);
        bus_if.iCaterr_n = 1'b0;
        repeat (6) @(negedge clk);
        chk("ar_active_hi", 32'(bus_if.oCaterrActive), 1);
        #2 rst = 1'b1;
        #1;
        m_cnt = 0;
        m_ms  = 0;
        m_is  = 0;
        chk("ar_active", 32'(bus_if.oCaterrActive), 0);
        chk_status("ar");
        bus_if.iCaterr_n = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("ar_drain", 32'(q.size()), 0);
        chk("ar_idle", 32'(bus_if.oCaterrActive), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
